// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - instruction-issue sequencer feeding a combinational ALU
// Decodes 16-bit words, reads an 8-entry register file, issues to the ALU and writes results back.
module alu_issue_seq #(
    parameter int DATA_W = 16,
    parameter int OP_W   = 6,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              alu_rst_n,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_wb_data,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [7:0]        out_byte,
    output logic              busy
);

    localparam int RD_LSB  = 16 - OP_W - REG_AW;
    localparam int RS1_LSB = RD_LSB - REG_AW;
    localparam int RS2_LSB = RS1_LSB - REG_AW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2,
        S_IMM   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_regs [2**REG_AW];
    logic [REG_AW-1:0]   r_rd;
    logic [OP_W-1:0]     r_opcode;
    logic [DATA_W-1:0]   r_in1;
    logic [DATA_W-1:0]   r_in2;
    logic [REG_AW-1:0]   r_wb_addr;
    logic [DATA_W-1:0]   r_wb_data;

    logic                w_ready;
    logic                w_xfer;
    logic [OP_W-1:0]     w_op;
    logic [REG_AW-1:0]   w_rd;
    logic [REG_AW-1:0]   w_rs1;
    logic [REG_AW-1:0]   w_rs2;
    logic                w_ldi;
    logic [DATA_W-1:0]   w_rs1_val;
    logic [DATA_W-1:0]   w_rs2_val;
    logic                w_wb_en;
    logic [DATA_W-1:0]   w_wb_val;

    assign w_op   = instr[15 -: OP_W];
    assign w_rd   = instr[RD_LSB  +: REG_AW];
    assign w_rs1  = instr[RS1_LSB +: REG_AW];
    assign w_rs2  = instr[RS2_LSB +: REG_AW];
    assign w_ldi  = instr[0];
    assign w_xfer = instr_valid && w_ready;

    // r0 always reads as zero regardless of array contents
    assign w_rs1_val = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_xfer) w_state_nxt = w_ldi ? S_IMM : S_ISSUE;
            S_ISSUE: w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            S_IMM:   if (w_xfer) w_state_nxt = S_WB;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready  = ((r_state == S_IDLE) || (r_state == S_IMM)) && !rst;
        busy     = (r_state != S_IDLE);
        wb_valid = (r_state == S_WB);
    end

    // Writeback source: ALU result at the end of ISSUE, or the immediate word in IMM
    always_comb begin
        w_wb_en  = 1'b0;
        w_wb_val = alu_wb_data;
        if (r_state == S_ISSUE) begin
            w_wb_en = 1'b1;
        end else if ((r_state == S_IMM) && w_xfer) begin
            w_wb_en  = 1'b1;
            w_wb_val = DATA_W'(instr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_regs    <= '{default: '0};
            r_rd      <= '0;
            r_opcode  <= '0;
            r_in1     <= '0;
            r_in2     <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_xfer) begin
                r_rd <= w_rd;
                if (!w_ldi) begin
                    r_opcode <= w_op;
                    r_in1    <= w_rs1_val;
                    r_in2    <= w_rs2_val;
                end
            end
            if (w_wb_en) begin
                r_wb_addr <= r_rd;
                r_wb_data <= w_wb_val;
                if (r_rd != '0) begin
                    r_regs[r_rd] <= w_wb_val;
                end
            end
        end
    end

    assign instr_ready = w_ready;
    assign alu_rst_n   = ~rst;
    assign alu_opcode  = r_opcode;
    assign alu_in1     = r_in1;
    assign alu_in2     = r_in2;
    assign wb_addr     = r_wb_addr;
    assign wb_data     = r_wb_data;
    assign out_byte    = r_wb_data[7:0];

endmodule
